bus_arbiter: RTL and testbench

//  Shares the single 16-bit memory/IO bus (address, write data, wen, iom, read data) between
//  two requesters: port 0 = CPU core, port 1 = DMA/debug master. Latches the winner's request,

---
 rtl/bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port arbiter for the shared 16-bit memory/IO bus.
// Port 0 is the CPU core and port 1 is the DMA/debug master. The arbiter
// grants one port, latches its request, and runs one handshaked bus
// transaction. It then pulses ack (or err on timeout) back to the owner.
module bus_arbiter #(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int TIMEOUT   = 15,
    parameter int CPU_PRIO  = 1,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_a,
    input  logic [DW-1:0] r0_d,
    input  logic          r0_wen,
    input  logic          r0_iom,
    output logic          r0_ack,
    output logic          r0_err,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_a,
    input  logic [DW-1:0] r1_d,
    input  logic          r1_wen,
    input  logic          r1_iom,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [DW-1:0] rdata_out,
    output logic [AW-1:0] a_out,
    output logic [DW-1:0] d_out,
    output logic          wen_out,
    output logic          iom_out,
    output logic          mem_req_out,
    input  logic          mem_ack_in,
    input  logic [DW-1:0] d_in,
    output logic          owner_out,
    output logic          busy_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_gnt;
    logic [7:0] burst_cnt;
    logic [7:0] tmo_cnt;

    logic       winner;
    logic [7:0] burst_nxt;

    // Pick the winning port and the next fairness count for an IDLE grant decision
    always_comb begin
        winner    = 1'b0;
        burst_nxt = 8'd0;
        if (r0_req && r1_req) begin
            if (CPU_PRIO != 0) begin
                // CPU wins ties until it has used up its burst allowance
                winner = (burst_cnt == BURST_LIM);
            end else begin
                winner = ~last_gnt;
            end
        end else begin
            // Single requester (or none, in which case nothing is granted)
            winner = r1_req;
        end
        if (CPU_PRIO != 0 && !winner && r1_req) begin
            burst_nxt = (burst_cnt == BURST_LIM) ? burst_cnt : burst_cnt + 8'd1;
        end
    end

    // Arbiter FSM: grant, run the bus cycle, pulse the response, all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            burst_cnt   <= 8'd0;
            tmo_cnt     <= 8'd0;
            r0_ack      <= 1'b0;
            r0_err      <= 1'b0;
            r1_ack      <= 1'b0;
            r1_err      <= 1'b0;
            rdata_out   <= '0;
            a_out       <= '0;
            d_out       <= '0;
            wen_out     <= 1'b0;
            iom_out     <= 1'b0;
            mem_req_out <= 1'b0;
            owner_out   <= 1'b0;
            busy_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner_out   <= winner;
                        last_gnt    <= winner;
                        burst_cnt   <= burst_nxt;
                        tmo_cnt     <= 8'd0;
                        a_out       <= winner ? r1_a   : r0_a;
                        d_out       <= winner ? r1_d   : r0_d;
                        wen_out     <= winner ? r1_wen : r0_wen;
                        iom_out     <= winner ? r1_iom : r0_iom;
                        mem_req_out <= 1'b1;
                        busy_out    <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ack_in || tmo_cnt == TMO_LAST) begin
                        // A completion on the expiry cycle still counts as success
                        if (mem_ack_in) begin
                            rdata_out <= wen_out ? '0 : d_in;
                            r0_ack    <= ~owner_out;
                            r1_ack    <= owner_out;
                        end else begin
                            rdata_out <= '0;
                            r0_err    <= ~owner_out;
                            r1_err    <= owner_out;
                        end
                        a_out       <= '0;
                        d_out       <= '0;
                        wen_out     <= 1'b0;
                        iom_out     <= 1'b0;
                        mem_req_out <= 1'b0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                RESP: begin
                    r0_ack   <= 1'b0;
                    r0_err   <= 1'b0;
                    r1_ack   <= 1'b0;
                    r1_err   <= 1'b0;
                    tmo_cnt  <= 8'd0;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: one fixed-priority and one round-robin instance
// share the same stimulus and respond in lockstep.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_wen, r0_iom, r1_req, r1_wen, r1_iom;
    logic [15:0] r0_a, r0_d, r1_a, r1_d, d_in;
    logic        mem_ack_in;

    logic        r0_ack, r0_err, r1_ack, r1_err, wen_out, iom_out, mem_req_out, owner_out, busy_out;
    logic [15:0] rdata_out, a_out, d_out;
    logic        rr_r0_ack, rr_r0_err, rr_r1_ack, rr_r1_err, rr_wen, rr_iom, rr_mem_req, rr_owner, rr_busy;
    logic [15:0] rr_rdata, rr_a, rr_d;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.DW(16), .AW(16), .TIMEOUT(15), .CPU_PRIO(1), .BURST_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_a(r0_a), .r0_d(r0_d), .r0_wen(r0_wen), .r0_iom(r0_iom),
        .r0_ack(r0_ack), .r0_err(r0_err),
        .r1_req(r1_req), .r1_a(r1_a), .r1_d(r1_d), .r1_wen(r1_wen), .r1_iom(r1_iom),
        .r1_ack(r1_ack), .r1_err(r1_err),
        .rdata_out(rdata_out), .a_out(a_out), .d_out(d_out), .wen_out(wen_out),
        .iom_out(iom_out), .mem_req_out(mem_req_out), .mem_ack_in(mem_ack_in),
        .d_in(d_in), .owner_out(owner_out), .busy_out(busy_out)
    );

    bus_arbiter #(.DW(16), .AW(16), .TIMEOUT(15), .CPU_PRIO(0), .BURST_MAX(4)) u_rr (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_a(r0_a), .r0_d(r0_d), .r0_wen(r0_wen), .r0_iom(r0_iom),
        .r0_ack(rr_r0_ack), .r0_err(rr_r0_err),
        .r1_req(r1_req), .r1_a(r1_a), .r1_d(r1_d), .r1_wen(r1_wen), .r1_iom(r1_iom),
        .r1_ack(rr_r1_ack), .r1_err(rr_r1_err),
        .rdata_out(rr_rdata), .a_out(rr_a), .d_out(rr_d), .wen_out(rr_wen),
        .iom_out(rr_iom), .mem_req_out(rr_mem_req), .mem_ack_in(mem_ack_in),
        .d_in(d_in), .owner_out(rr_owner), .busy_out(rr_busy)
    );

    typedef struct {
        logic        port;
        logic        wen;
        logic        iom;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] mdata;
        int          dly;      // ACCESS cycle on which memory acks; 0 = never
        int          drop_at;  // ACCESS cycle on which the requester drops/scrambles; 0 = never
        logic        exp_err;
        logic [15:0] exp_rdata;
        int          exp_acc;
    } vec_t;

    typedef struct {
        logic        port;
        logic        rr_port;
        logic        wen;
        logic        iom;
        logic [15:0] a;
        logic [15:0] d;
        logic        err;
        logic [15:0] rdata;
        int          acc;
    } exp_t;

    vec_t vt[7];
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {r0_ack, r0_err, r1_ack, r1_err, rdata_out, a_out, d_out, wen_out,
                 iom_out, mem_req_out, owner_out, busy_out}, 64'd0);
        chk({nm, "_rr"}, {rr_r0_ack, rr_r0_err, rr_r1_ack, rr_r1_err, rr_rdata, rr_a, rr_d,
                          rr_wen, rr_iom, rr_mem_req, rr_owner, rr_busy}, 64'd0);
    endtask

    // Services the bus until n_resp responses are seen, popping the scoreboard on each.
    task automatic run_bus(input int n_resp, input int dly, input logic [15:0] mdata,
                           input int drop_at, input bit hold);
        int   acc = 0;
        int   got = 0;
        int   cyc = 0;
        logic resp;
        exp_t e;
        logic [15:0] last_rd = 16'h0;
        while (got < n_resp && cyc < 400) begin
            @(negedge clk);
            cyc++;
            resp = r0_ack | r0_err | r1_ack | r1_err;
            chk("busy", busy_out, mem_req_out | resp);
            if (mem_req_out) begin
                acc++;
                if (sbq.size() == 0) begin
                    chk("unexpected_access", 1'b1, 1'b0);
                end else begin
                    e = sbq[0];
                    chk("owner", owner_out, e.port);
                    chk("a_out", a_out, e.a);
                    chk("d_out", d_out, e.d);
                    chk("wen_iom", {wen_out, iom_out}, {e.wen, e.iom});
                    if (!hold && acc == drop_at) begin
                        if (e.port) begin
                            r1_req = 1'b0; r1_a = ~r1_a; r1_d = ~r1_d;
                        end else begin
                            r0_req = 1'b0; r0_a = ~r0_a; r0_d = ~r0_d;
                        end
                    end
                end
                mem_ack_in = (dly != 0 && acc == dly);
                d_in = mem_ack_in ? mdata : 16'($urandom);
            end else begin
                chk("idle_bus", {a_out, d_out, wen_out, iom_out}, 34'd0);
                mem_ack_in = 1'b0;
                d_in = 16'($urandom);
            end
            if (resp) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_port", r1_ack | r1_err, e.port);
                    chk("resp_err", r0_err | r1_err, e.err);
                    chk("resp_onehot", 32'(r0_ack) + 32'(r0_err) + 32'(r1_ack) + 32'(r1_err), 32'd1);
                    chk("rdata", rdata_out, e.rdata);
                    chk("access_cycles", acc, e.acc);
                    chk("rr_resp_port", {rr_r0_ack | rr_r0_err, rr_r1_ack | rr_r1_err},
                        e.rr_port ? 2'b01 : 2'b10);
                    last_rd = e.rdata;
                end
                acc = 0;
                got++;
                if (!hold) begin
                    r0_req = 1'b0;
                    r1_req = 1'b0;
                end
            end
        end
        if (got < n_resp) chk("resp_timeout", got, n_resp);
        @(negedge clk);
        chk("pulse_one_cycle", {r0_ack, r0_err, r1_ack, r1_err}, 4'd0);
        if (!hold) chk("rdata_hold", rdata_out, last_rd);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        if (v.port) begin
            r1_req = 1'b1; r1_a = v.a; r1_d = v.d; r1_wen = v.wen; r1_iom = v.iom;
        end else begin
            r0_req = 1'b1; r0_a = v.a; r0_d = v.d; r0_wen = v.wen; r0_iom = v.iom;
        end
        e = '{port: v.port, rr_port: v.port, wen: v.wen, iom: v.iom, a: v.a, d: v.d,
              err: v.exp_err, rdata: v.exp_rdata, acc: v.exp_acc};
        sbq.push_back(e);
        run_bus(1, v.dly, v.mdata, v.drop_at, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1'b0; r1_req = 1'b0; mem_ack_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        logic [15:0] prev_rd;
        //        port wen iom a        d        mdata    dly drop err rdata    acc
        vt[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 2,  0, 1'b0, 16'h1234, 2};
        vt[1] = '{1'b1, 1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h5555, 1,  0, 1'b0, 16'h0000, 1};
        vt[2] = '{1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h9999, 0,  0, 1'b1, 16'h0000, 15};
        vt[3] = '{1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hA5A5, 15, 0, 1'b0, 16'hA5A5, 15};
        vt[4] = '{1'b0, 1'b1, 1'b0, 16'h8001, 16'h0001, 16'h7E7E, 3,  1, 1'b0, 16'h0000, 3};
        vt[5] = '{1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'hFFFF, 1,  1, 1'b0, 16'hFFFF, 1};
        vt[6] = '{1'b1, 1'b0, 1'b1, 16'h0300, 16'h0000, 16'h3C3C, 0,  5, 1'b1, 16'h0000, 15};

        rst = 1'b1;
        r0_req = 1'b0; r0_a = 16'h0; r0_d = 16'h0; r0_wen = 1'b0; r0_iom = 1'b0;
        r1_req = 1'b0; r1_a = 16'h0; r1_d = 16'h0; r1_wen = 1'b0; r1_iom = 1'b0;
        mem_ack_in = 1'b0; d_in = 16'h0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset_state");
        rst = 1'b0;

        // Single transactions from the vector table
        for (int i = 0; i < 7; i++) run_vec(vt[i]);

        // Memory completion with no transaction in flight is ignored
        prev_rd = rdata_out;
        @(negedge clk);
        mem_ack_in = 1'b1; d_in = 16'h7777;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_ack_idle", {r0_ack, r0_err, r1_ack, r1_err, busy_out, mem_req_out}, 6'd0);
            chk("stray_ack_rdata", rdata_out, prev_rd);
        end
        mem_ack_in = 1'b0;

        // Reset in the middle of ACCESS: outputs clear, no response pulse
        @(negedge clk);
        r0_req = 1'b1; r0_a = 16'h0042; r0_wen = 1'b0; r0_iom = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk("mid_access_req", {mem_req_out, busy_out, a_out}, {2'b11, 16'h0042});
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("reset_mid_access");
        rst = 1'b0;
        r0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_resp_after_reset", {r0_ack, r0_err, r1_ack, r1_err, busy_out}, 5'd0);
        end
        run_vec(vt[1]);

        // Both ports held continuously, memory acks on the first ACCESS cycle
        do_reset();
        @(negedge clk);
        r0_req = 1'b1; r0_a = 16'h0100; r0_d = 16'h0000; r0_wen = 1'b0; r0_iom = 1'b0;
        r1_req = 1'b1; r1_a = 16'h0300; r1_d = 16'h0000; r1_wen = 1'b0; r1_iom = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e.port    = (i == 4 || i == 9);
            e.rr_port = (i % 2 == 1);
            e.wen     = 1'b0;
            e.iom     = 1'b0;
            e.a       = e.port ? 16'h0300 : 16'h0100;
            e.d       = 16'h0000;
            e.err     = 1'b0;
            e.rdata   = 16'h0C0C;
            e.acc     = 1;
            sbq.push_back(e);
        end
        run_bus(10, 1, 16'h0C0C, 0, 1'b1);
        r0_req = 1'b0; r1_req = 1'b0;
        do_reset();
        chk("scoreboard_drained", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
